fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// registers the returned word into the IF/ID register for decode.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | fetching sequentially; PC advances on every non-stalled edge
// HALTED | halt opcode seen; PC parked on the halt address until redirect
module fetch_stage #(
  parameter int unsigned            PC_W     = 16,
  parameter int unsigned            INSTR_W  = 23,
  parameter int unsigned            OP_W     = 5,
  parameter logic [OP_W-1:0]        HALT_OP  = 5'b11111,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               stall_i,
  input  logic               br_taken_i,
  input  logic [PC_W-1:0]    br_target_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic               id_valid_o,
  output logic               halted_o,
  output logic [15:0]        fetch_cnt_o
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   id_instr_q, id_instr_d;
  logic [PC_W-1:0]      id_pc_q, id_pc_d;
  logic                 id_valid_q, id_valid_d;
  logic [15:0]          fetch_cnt_q, fetch_cnt_d;
  logic                 is_halt;

  assign is_halt = (instr_i[INSTR_W-1 -: OP_W] == HALT_OP);

  // State register plus IF/ID pipeline register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Next-state: redirect beats stall, stall beats normal fetch/halt handling.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    fetch_cnt_d = fetch_cnt_q;

    if (br_taken_i) begin
      // Redirect squashes whatever is in flight, including a halt word.
      pc_d       = br_target_i;
      id_valid_d = 1'b0;
      state_d    = RUN;
    end else if (!stall_i) begin
      unique case (state_q)
        RUN: begin
          id_instr_d = instr_i;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          if (fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
          end
          if (is_halt) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        HALTED: begin
          // Halt word has now been accepted by decode; stop presenting it.
          id_valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign id_valid_o  = id_valid_q;
  assign halted_o    = (state_q == HALTED);
  assign fetch_cnt_o = fetch_cnt_q;

endmodule
